// File: rtl/flash_arb_pkg.sv
// rtl/flash_arb_pkg.sv - shared types and parked-pin constants for the flash pin arbiter
package flash_arb_pkg;

    typedef enum logic [1:0] {
        ST_OWN_A   = 2'd0,
        ST_DRAIN_A = 2'd1,
        ST_OWN_B   = 2'd2,
        ST_DRAIN_B = 2'd3
    } flash_arb_state_t;

    localparam logic       FLASH_PARK_CSB = 1'b1;
    localparam logic       FLASH_PARK_CLK = 1'b0;
    localparam logic [3:0] FLASH_PARK_OE  = 4'h0;
    localparam logic [3:0] FLASH_PARK_DO  = 4'h0;

    function automatic int unsigned flash_arb_max(input int unsigned x, input int unsigned y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/flash_arb_pin_mux.sv
// rtl/flash_arb_pin_mux.sv - combinational A/B/park select for the flash pins and di gating
module flash_arb_pin_mux
    import flash_arb_pkg::*;
(
    input  flash_arb_state_t state,
    input  logic             a_csb,
    input  logic             a_clk,
    input  logic [3:0]       a_io_oe,
    input  logic [3:0]       a_io_do,
    output logic [3:0]       a_io_di,
    input  logic             b_csb,
    input  logic             b_clk,
    input  logic [3:0]       b_io_oe,
    input  logic [3:0]       b_io_do,
    output logic [3:0]       b_io_di,
    output logic             flash_csb,
    output logic             flash_clk,
    output logic [3:0]       flash_io_oe,
    output logic [3:0]       flash_io_do,
    input  logic [3:0]       flash_io_di
);

    always_comb begin
        flash_csb   = FLASH_PARK_CSB;
        flash_clk   = FLASH_PARK_CLK;
        flash_io_oe = FLASH_PARK_OE;
        flash_io_do = FLASH_PARK_DO;
        a_io_di     = 4'h0;
        b_io_di     = 4'h0;
        case (state)
            ST_OWN_A: begin
                flash_csb   = a_csb;
                flash_clk   = a_clk;
                flash_io_oe = a_io_oe;
                flash_io_do = a_io_do;
                a_io_di     = flash_io_di;
            end
            ST_OWN_B: begin
                flash_csb   = b_csb;
                flash_clk   = b_clk;
                flash_io_oe = b_io_oe;
                flash_io_do = b_io_do;
                b_io_di     = flash_io_di;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/flash_pin_arbiter.sv
// rtl/flash_pin_arbiter.sv - two-master quad-SPI pin arbiter; optional B idle timeout via FLASH_ARB_TIMEOUT_EN
module flash_pin_arbiter
    import flash_arb_pkg::*;
#(
    parameter int unsigned GUARD_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       a_csb,
    input  logic       a_clk,
    input  logic [3:0] a_io_oe,
    input  logic [3:0] a_io_do,
    output logic [3:0] a_io_di,
    output logic       a_hold,
    input  logic       b_req,
    output logic       b_gnt,
    input  logic       b_csb,
    input  logic       b_clk,
    input  logic [3:0] b_io_oe,
    input  logic [3:0] b_io_do,
    output logic [3:0] b_io_di,
    output logic       b_timeout,
    output logic       flash_csb,
    output logic       flash_clk,
    output logic [3:0] flash_io_oe,
    output logic [3:0] flash_io_do,
    input  logic [3:0] flash_io_di
);

    localparam int unsigned    CNT_W      = $clog2(flash_arb_max(GUARD_CYCLES, TIMEOUT_CYCLES) + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);

    flash_arb_state_t state;
    flash_arb_state_t state_next;
    logic [CNT_W-1:0] guard_cnt;
    logic [CNT_W-1:0] guard_next;
    logic             lockout;
    logic             timeout_fire;

`ifdef FLASH_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] timeout_cnt;
    logic             timeout_q;

    // An explicit release request wins over a simultaneous timeout, so no pulse then.
    assign timeout_fire = (state == ST_OWN_B) && b_req && b_csb && (timeout_cnt == TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            timeout_cnt <= '0;
            lockout     <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            timeout_q <= timeout_fire;
            if (timeout_fire) begin
                lockout <= 1'b1;
            end else if (!b_req) begin
                lockout <= 1'b0;
            end
            if ((state == ST_OWN_B) && b_csb) begin
                timeout_cnt <= (timeout_cnt == CNT_MAX) ? timeout_cnt : timeout_cnt + 1'b1;
            end else begin
                timeout_cnt <= '0;
            end
        end
    end

    assign b_timeout = timeout_q;
`else
    assign timeout_fire = 1'b0;
    assign lockout      = 1'b0;
    assign b_timeout    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= ST_OWN_A;
            guard_cnt <= '0;
        end else begin
            state     <= state_next;
            guard_cnt <= guard_next;
        end
    end

    always_comb begin
        state_next = state;
        guard_next = (guard_cnt == CNT_MAX) ? guard_cnt : guard_cnt + 1'b1;
        case (state)
            ST_OWN_A: begin
                if (b_req && !lockout) begin
                    state_next = ST_DRAIN_A;
                end
            end
            ST_DRAIN_A: begin
                // The guard interval only counts cycles where A has actually let go of CSB.
                if (!b_req) begin
                    state_next = ST_DRAIN_B;
                end else if (!a_csb) begin
                    guard_next = '0;
                end else if (guard_cnt == GUARD_LAST) begin
                    state_next = ST_OWN_B;
                end
            end
            ST_OWN_B: begin
                if (!b_req || timeout_fire) begin
                    state_next = ST_DRAIN_B;
                end
            end
            ST_DRAIN_B: begin
                if (guard_cnt == GUARD_LAST) begin
                    state_next = ST_OWN_A;
                end
            end
            default: begin
                state_next = ST_OWN_A;
            end
        endcase
        if (state_next != state) begin
            guard_next = '0;
        end
    end

    assign a_hold = (state != ST_OWN_A);
    assign b_gnt  = (state == ST_OWN_B);

    flash_arb_pin_mux u_pin_mux (
        .state       (state),
        .a_csb       (a_csb),
        .a_clk       (a_clk),
        .a_io_oe     (a_io_oe),
        .a_io_do     (a_io_do),
        .a_io_di     (a_io_di),
        .b_csb       (b_csb),
        .b_clk       (b_clk),
        .b_io_oe     (b_io_oe),
        .b_io_do     (b_io_do),
        .b_io_di     (b_io_di),
        .flash_csb   (flash_csb),
        .flash_clk   (flash_clk),
        .flash_io_oe (flash_io_oe),
        .flash_io_do (flash_io_do),
        .flash_io_di (flash_io_di)
    );

endmodule
